// File: rtl/ctrl_pipe_if.sv
// Signal bundle between the ID-stage front end and the pipelined control unit.
// The control unit is the slave; whoever drives the ID-stage fields is the master.
interface ctrl_pipe_if #(
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_W      = 16
);
    logic                  valid_i;
    logic [6:0]            opcode_i;
    logic [4:0]            rs1_i;
    logic [4:0]            rs2_i;
    logic [4:0]            rd_i;
    logic                  flush_i;
    logic [CTRL_WIDTH-1:0] ctrl_ex_o;
    logic [CTRL_WIDTH-1:0] ctrl_mem_o;
    logic [CTRL_WIDTH-1:0] ctrl_wb_o;
    logic [4:0]            rd_wb_o;
    logic                  stall_o;
    logic                  illegal_o;
    logic                  illegal_seen_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output valid_i, opcode_i, rs1_i, rs2_i, rd_i, flush_i,
        input  ctrl_ex_o, ctrl_mem_o, ctrl_wb_o, rd_wb_o,
               stall_o, illegal_o, illegal_seen_o, stall_cnt_o
    );

    modport slave (
        input  valid_i, opcode_i, rs1_i, rs2_i, rd_i, flush_i,
        output ctrl_ex_o, ctrl_mem_o, ctrl_wb_o, rd_wb_o,
               stall_o, illegal_o, illegal_seen_o, stall_cnt_o
    );
endinterface

// File: rtl/ctrl_pipe.sv
// RV32I pipelined control unit: decodes the ID opcode, carries the control bundle and rd
// through ID/EX, EX/MEM and MEM/WB, and handles load-use stalls, flushes and illegal opcodes.
module ctrl_pipe #(
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ctrl_pipe_if.slave    bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [CTRL_WIDTH-1:0] ctrl_stage_reg [3];
    logic [4:0]            rd_stage_reg   [3];
    logic                  illegal_reg;
    logic                  illegal_seen_reg;
    logic [CNT_W-1:0]      stall_cnt_reg;

    logic [CTRL_WIDTH-1:0] ctrl_id;
    logic                  rs1_used;
    logic                  rs2_used;
    logic                  hazard;
    logic                  stall;
    logic                  bubble;

    // Decode; an invalid ID slot decodes to the all-zero bubble.
    always_comb begin
        ctrl_id  = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        if (bus.valid_i) begin
            unique case (bus.opcode_i)
                OP_R:      begin ctrl_id[1] = 1'b1; ctrl_id[5] = 1'b1; ctrl_id[7:6] = 2'b10;
                                 rs1_used = 1'b1; rs2_used = 1'b1; end
                OP_I:      begin ctrl_id[1] = 1'b1; ctrl_id[7:6] = 2'b10; rs1_used = 1'b1; end
                OP_LOAD:   begin ctrl_id[0] = 1'b1; ctrl_id[1] = 1'b1; ctrl_id[3] = 1'b1;
                                 rs1_used = 1'b1; end
                OP_STORE:  begin ctrl_id[2] = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
                OP_BRANCH: begin ctrl_id[4] = 1'b1; ctrl_id[5] = 1'b1; ctrl_id[7:6] = 2'b01;
                                 rs1_used = 1'b1; rs2_used = 1'b1; end
                OP_JAL:    begin ctrl_id[1] = 1'b1; ctrl_id[8] = 1'b1; end
                OP_JALR:   begin ctrl_id[1] = 1'b1; ctrl_id[9] = 1'b1; rs1_used = 1'b1; end
                OP_LUI:    begin ctrl_id[1] = 1'b1; ctrl_id[10] = 1'b1; end
                OP_AUIPC:  begin ctrl_id[1] = 1'b1; ctrl_id[11] = 1'b1; end
                default:   ctrl_id[12] = 1'b1;
            endcase
        end
    end

    assign hazard = ctrl_stage_reg[0][3] && (rd_stage_reg[0] != 5'd0) && bus.valid_i &&
                    ((rs1_used && (bus.rs1_i == rd_stage_reg[0])) ||
                     (rs2_used && (bus.rs2_i == rd_stage_reg[0])));
    // A taken flush kills the ID instruction anyway, so holding IF/ID would be pointless.
    assign stall  = hazard && !bus.flush_i;
    assign bubble = hazard || bus.flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_stage_reg[0] <= '0;
            rd_stage_reg[0]   <= '0;
        end else if (bubble) begin
            ctrl_stage_reg[0] <= '0;
            rd_stage_reg[0]   <= '0;
        end else begin
            ctrl_stage_reg[0] <= ctrl_id;
            rd_stage_reg[0]   <= bus.valid_i ? bus.rd_i : 5'd0;
        end
    end

    // EX/MEM and MEM/WB advance unconditionally.
    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_stage
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ctrl_stage_reg[gi] <= '0;
                    rd_stage_reg[gi]   <= '0;
                end else begin
                    ctrl_stage_reg[gi] <= ctrl_stage_reg[gi-1];
                    rd_stage_reg[gi]   <= rd_stage_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            illegal_reg      <= 1'b0;
            illegal_seen_reg <= 1'b0;
            stall_cnt_reg    <= '0;
        end else begin
            illegal_reg      <= ctrl_stage_reg[0][12];
            illegal_seen_reg <= illegal_seen_reg | ctrl_stage_reg[0][12];
            if (stall && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign bus.ctrl_ex_o      = ctrl_stage_reg[0];
    assign bus.ctrl_mem_o     = ctrl_stage_reg[1];
    assign bus.ctrl_wb_o      = ctrl_stage_reg[2];
    assign bus.rd_wb_o        = rd_stage_reg[2];
    assign bus.stall_o        = stall;
    assign bus.illegal_o      = illegal_reg;
    assign bus.illegal_seen_o = illegal_seen_reg;
    assign bus.stall_cnt_o    = stall_cnt_reg;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a default-width instance for the main scenarios and a
// CNT_W=2 instance for counter saturation and mid-stall reset.
module tb_ctrl_pipe;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_cnt = 0;

    ctrl_pipe_if #(.CTRL_WIDTH(16), .CNT_W(16)) bus ();
    ctrl_pipe_if #(.CTRL_WIDTH(16), .CNT_W(2))  sbus ();

    ctrl_pipe #(.CTRL_WIDTH(16), .CNT_W(16)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));
    ctrl_pipe #(.CTRL_WIDTH(16), .CNT_W(2))  dut_sat (.clk_i(clk), .rst_ni(rst_n), .bus(sbus.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic fl);
        bus.valid_i = v; bus.opcode_i = op; bus.rs1_i = rs1; bus.rs2_i = rs2;
        bus.rd_i = rd; bus.flush_i = fl;
        #1;
    endtask

    task automatic sdrive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                          input logic [4:0] rd);
        sbus.valid_i = v; sbus.opcode_i = op; sbus.rs1_i = rs1; sbus.rs2_i = 5'd0;
        sbus.rd_i = rd; sbus.flush_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        sdrive(1'b0, 7'd0, 5'd0, 5'd0);
        #2;
        vectors++; if (bus.ctrl_ex_o !== 16'h0) begin miscompares++; $display("FAIL reset_ex got %h want 0000", bus.ctrl_ex_o); end
        vectors++; if (bus.ctrl_wb_o !== 16'h0 || bus.rd_wb_o !== 5'd0) begin miscompares++; $display("FAIL reset_wb got %h/%0d want 0000/0", bus.ctrl_wb_o, bus.rd_wb_o); end
        vectors++; if (bus.stall_cnt_o !== 16'd0 || bus.illegal_seen_o !== 1'b0) begin miscompares++; $display("FAIL reset_misc cnt %0d seen %b want 0/0", bus.stall_cnt_o, bus.illegal_seen_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_add_latency();
        drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        vectors++; if (bus.ctrl_ex_o !== 16'h00A2) begin miscompares++; $display("FAIL add_ex got %h want 00a2", bus.ctrl_ex_o); end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        vectors++; if (bus.ctrl_mem_o !== 16'h00A2 || bus.ctrl_ex_o !== 16'h0) begin miscompares++; $display("FAIL add_mem got mem %h ex %h want 00a2/0000", bus.ctrl_mem_o, bus.ctrl_ex_o); end
        tick();
        vectors++; if (bus.ctrl_wb_o !== 16'h00A2 || bus.rd_wb_o !== 5'd3) begin miscompares++; $display("FAIL add_wb got %h rd %0d want 00a2 rd 3", bus.ctrl_wb_o, bus.rd_wb_o); end
        $display("ADD x3 latency checked");
    endtask

    task automatic test_load_use();
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        vectors++; if (bus.ctrl_ex_o !== 16'h000B) begin miscompares++; $display("FAIL lw_ex got %h want 000b", bus.ctrl_ex_o); end
        drive(1'b1, OP_R, 5'd5, 5'd2, 5'd7, 1'b0);
        vectors++; if (bus.stall_o !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %b want 1", bus.stall_o); end
        tick();
        exp_cnt++;
        vectors++; if (bus.ctrl_ex_o !== 16'h0 || bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL lu_bubble ex %h stall %b want 0000/0", bus.ctrl_ex_o, bus.stall_o); end
        vectors++; if (bus.stall_cnt_o !== 16'(exp_cnt)) begin miscompares++; $display("FAIL lu_cnt got %0d want %0d", bus.stall_cnt_o, exp_cnt); end
        tick();
        vectors++; if (bus.ctrl_ex_o !== 16'h00A2) begin miscompares++; $display("FAIL lu_add_ex got %h want 00a2", bus.ctrl_ex_o); end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        $display("LW x5 / ADD x7,x5 stalled once");
    endtask

    task automatic test_no_stall();
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, OP_R, 5'd0, 5'd0, 5'd8, 1'b0);
        vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL x0_stall got %b want 0", bus.stall_o); end
        tick();
        vectors++; if (bus.ctrl_ex_o !== 16'h00A2) begin miscompares++; $display("FAIL x0_ex got %h want 00a2", bus.ctrl_ex_o); end
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        drive(1'b1, OP_LUI, 5'd5, 5'd5, 5'd6, 1'b0);
        vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL lui_stall got %b want 0", bus.stall_o); end
        tick();
        vectors++; if (bus.ctrl_ex_o !== 16'h0402 || bus.stall_cnt_o !== 16'(exp_cnt)) begin miscompares++; $display("FAIL lui_ex got %h cnt %0d want 0402 cnt %0d", bus.ctrl_ex_o, bus.stall_cnt_o, exp_cnt); end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        $display("rd=x0 and LUI cases did not stall");
    endtask

    task automatic test_flush();
        drive(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        drive(1'b1, OP_R, 5'd3, 5'd5, 5'd9, 1'b1);
        vectors++; if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL flush_stall got %b want 0", bus.stall_o); end
        tick();
        vectors++; if (bus.ctrl_ex_o !== 16'h0 || bus.stall_cnt_o !== 16'(exp_cnt)) begin miscompares++; $display("FAIL flush_ex got %h cnt %0d want 0000 cnt %0d", bus.ctrl_ex_o, bus.stall_cnt_o, exp_cnt); end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        $display("flush over load-use hazard inserted bubble");
    endtask

    task automatic test_illegal();
        drive(1'b1, OP_BAD, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        vectors++; if (bus.ctrl_ex_o !== 16'h1000 || bus.illegal_o !== 1'b0) begin miscompares++; $display("FAIL ill_ex got %h pulse %b want 1000/0", bus.ctrl_ex_o, bus.illegal_o); end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        vectors++; if (bus.illegal_o !== 1'b1) begin miscompares++; $display("FAIL ill_pulse got %b want 1", bus.illegal_o); end
        tick();
        vectors++; if (bus.illegal_o !== 1'b0 || bus.illegal_seen_o !== 1'b1) begin miscompares++; $display("FAIL ill_after pulse %b seen %b want 0/1", bus.illegal_o, bus.illegal_seen_o); end
        repeat (3) tick();
        vectors++; if (bus.illegal_seen_o !== 1'b1) begin miscompares++; $display("FAIL ill_sticky got %b want 1", bus.illegal_seen_o); end
        $display("illegal opcode 7f flagged");
    endtask

    task automatic test_saturation();
        logic [1:0] want;
        for (int i = 1; i <= 4; i++) begin
            sdrive(1'b1, OP_LOAD, 5'd1, 5'd5);
            tick();
            sdrive(1'b1, OP_R, 5'd5, 5'd7);
            vectors++; if (sbus.stall_o !== 1'b1) begin miscompares++; $display("FAIL sat_stall%0d got %b want 1", i, sbus.stall_o); end
            tick();
            want = (i >= 3) ? 2'd3 : 2'(i);
            vectors++; if (sbus.stall_cnt_o !== want) begin miscompares++; $display("FAIL sat_cnt%0d got %0d want %0d", i, sbus.stall_cnt_o, want); end
            $display("saturation stall %0d count %0d", i, sbus.stall_cnt_o);
        end
        sdrive(1'b1, OP_LOAD, 5'd1, 5'd5);
        tick();
        sdrive(1'b1, OP_R, 5'd5, 5'd7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (sbus.stall_o !== 1'b0 || sbus.ctrl_ex_o !== 16'h0 || sbus.stall_cnt_o !== 2'd0) begin miscompares++; $display("FAIL midrst_sat stall %b ex %h cnt %0d want 0/0000/0", sbus.stall_o, sbus.ctrl_ex_o, sbus.stall_cnt_o); end
        vectors++; if (bus.illegal_seen_o !== 1'b0 || bus.stall_cnt_o !== 16'd0) begin miscompares++; $display("FAIL midrst_main seen %b cnt %0d want 0/0", bus.illegal_seen_o, bus.stall_cnt_o); end
        sdrive(1'b1, OP_R, 5'd1, 5'd7);
        #2;
        rst_n = 1'b1;
        tick();
        vectors++; if (sbus.ctrl_ex_o !== 16'h00A2) begin miscompares++; $display("FAIL post_rst_ex got %h want 00a2", sbus.ctrl_ex_o); end
        sdrive(1'b0, 7'd0, 5'd0, 5'd0);
        $display("mid-stall reset cleared outputs");
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_add_latency();
                test_load_use();
                test_no_stall();
                test_flush();
                test_illegal();
                test_saturation();
            end
            begin
                #100000;
                $display("FAIL timeout");
                $fatal(1, "timeout");
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
